mul_hilo_writeback: RTL and testbench

MUL_HILO_WRITEBACK -- requirements
Module: mul_hilo_writeback

---
 rtl/mul_hilo_writeback.sv | 129 ++++++++++++
 tb/tb_mul_hilo_writeback.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_writeback.sv
//------------------------------------------------------------------------------
// mul_hilo_writeback: latches a 64-bit multiplier product into HI/LO and drains
// both words over a valid/ready bus in a selectable order. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_hilo_writeback #(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        prod_valid,
  input  logic [63:0] product,
  output logic        prod_ready,
  output logic        bus_valid,
  output logic [31:0] bus_data,
  output logic        bus_sel,
  input  logic        bus_ready,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        ovf,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic        ovf_q, ovf_n;
  logic        bus_valid_q, bus_valid_n;
  logic [31:0] bus_data_q, bus_data_n;
  logic        bus_sel_q, bus_sel_n;
  logic        done_q, done_n;
  logic        prod_ready_q, prod_ready_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    hi_n        = hi_q;
    lo_n        = lo_q;
    ovf_n       = ovf_q;
    bus_valid_n = bus_valid_q;
    bus_data_n  = bus_data_q;
    bus_sel_n   = bus_sel_q;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (prod_valid) begin
          hi_n        = product[63:32];
          lo_n        = product[31:0];
          // Fits in signed 32 bits only when HI is a pure sign extension of LO.
          ovf_n       = (product[63:32] != {32{product[31]}});
          state_n     = SEND_FIRST;
          bus_valid_n = 1'b1;
          bus_data_n  = HI_FIRST ? product[63:32] : product[31:0];
          bus_sel_n   = HI_FIRST;
        end
      end
      SEND_FIRST: begin
        if (bus_ready) begin
          state_n    = SEND_SECOND;
          bus_data_n = HI_FIRST ? lo_q : hi_q;
          bus_sel_n  = !HI_FIRST;
        end
      end
      SEND_SECOND: begin
        if (bus_ready) begin
          state_n     = IDLE;
          bus_valid_n = 1'b0;
          done_n      = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        bus_valid_n = 1'b0;
      end
    endcase

    prod_ready_n = (state_n == IDLE);
  end

  // Every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      ovf_q        <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_data_q   <= 32'd0;
      bus_sel_q    <= 1'b0;
      done_q       <= 1'b0;
      prod_ready_q <= 1'b1;
    end else begin
      hi_q         <= hi_n;
      lo_q         <= lo_n;
      ovf_q        <= ovf_n;
      bus_valid_q  <= bus_valid_n;
      bus_data_q   <= bus_data_n;
      bus_sel_q    <= bus_sel_n;
      done_q       <= done_n;
      prod_ready_q <= prod_ready_n;
    end
  end

  assign prod_ready = prod_ready_q;
  assign bus_valid  = bus_valid_q;
  assign bus_data   = bus_data_q;
  assign bus_sel    = bus_sel_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign ovf        = ovf_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_hilo_writeback.sv
//------------------------------------------------------------------------------
// tb_mul_hilo_writeback: directed vector table, hand sequences and random
// traffic on both drain orders, checked against a word-queue model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_hilo_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        pv;
  logic [63:0] prod;
  logic        br;

  logic        pr0, bv0, sel0, ovf0, done0;
  logic [31:0] bd0, hi0, lo0;
  logic        pr1, bv1, sel1, ovf1, done1;
  logic [31:0] bd1, hi1, lo1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_hilo_writeback #(.HI_FIRST(1'b0)) dut0 (
    .clock(clk), .reset(rst), .prod_valid(pv), .product(prod), .prod_ready(pr0),
    .bus_valid(bv0), .bus_data(bd0), .bus_sel(sel0), .bus_ready(br),
    .hi_out(hi0), .lo_out(lo0), .ovf(ovf0), .done(done0)
  );

  mul_hilo_writeback #(.HI_FIRST(1'b1)) dut1 (
    .clock(clk), .reset(rst), .prod_valid(pv), .product(prod), .prod_ready(pr1),
    .bus_valid(bv1), .bus_data(bd1), .bus_sel(sel1), .bus_ready(br),
    .hi_out(hi1), .lo_out(lo1), .ovf(ovf1), .done(done1)
  );

  // Reference model: pending words as {sel, data} queues, one per drain order.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [31:0] m_hi, m_lo;
  logic        m_ovf, m_done;
  logic [32:0] m_last0, m_last1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    longint sp;
    if (rst) begin
      q0.delete(); q1.delete();
      m_hi = 0; m_lo = 0; m_ovf = 0; m_done = 0;
      m_last0 = 0; m_last1 = 0;
    end else begin
      m_done = 1'b0;
      if (q0.size() == 0) begin
        if (pv) begin
          m_hi  = prod[63:32];
          m_lo  = prod[31:0];
          sp    = $signed(prod);
          m_ovf = (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
          q0.push_back({1'b0, m_lo}); q0.push_back({1'b1, m_hi});
          q1.push_back({1'b1, m_hi}); q1.push_back({1'b0, m_lo});
        end
      end else if (br) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) m_done = 1'b1;
      end
      if (q0.size() > 0) m_last0 = q0[0];
      if (q1.size() > 0) m_last1 = q1[0];
    end
  endtask

  task automatic check_model();
    chk("d0.prod_ready", 64'(pr0),   64'(q0.size() == 0));
    chk("d0.bus_valid",  64'(bv0),   64'(q0.size() != 0));
    chk("d0.bus_data",   64'(bd0),   64'(m_last0[31:0]));
    chk("d0.bus_sel",    64'(sel0),  64'(m_last0[32]));
    chk("d0.done",       64'(done0), 64'(m_done));
    chk("d0.hi_out",     64'(hi0),   64'(m_hi));
    chk("d0.lo_out",     64'(lo0),   64'(m_lo));
    chk("d0.ovf",        64'(ovf0),  64'(m_ovf));
    chk("d1.prod_ready", 64'(pr1),   64'(q1.size() == 0));
    chk("d1.bus_valid",  64'(bv1),   64'(q1.size() != 0));
    chk("d1.bus_data",   64'(bd1),   64'(m_last1[31:0]));
    chk("d1.bus_sel",    64'(sel1),  64'(m_last1[32]));
    chk("d1.done",       64'(done1), 64'(m_done));
    chk("d1.hi_out",     64'(hi1),   64'(m_hi));
    chk("d1.lo_out",     64'(lo1),   64'(m_lo));
    chk("d1.ovf",        64'(ovf1),  64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst, pv;
    logic [63:0] prod;
    logic        br;
    logic        pr, bv;
    logic [31:0] bd;
    logic        sel, done;
    logic [31:0] hi, lo;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [63:0] p, input logic b,
                     input logic epr, input logic ebv, input logic [31:0] ebd,
                     input logic esel, input logic edone, input logic [31:0] ehi,
                     input logic [31:0] elo, input logic eovf);
    vec_t t;
    t.rst = r; t.pv = v; t.prod = p; t.br = b;
    t.pr = epr; t.bv = ebv; t.bd = ebd; t.sel = esel; t.done = edone;
    t.hi = ehi; t.lo = elo; t.ovf = eovf;
    tbl.push_back(t);
  endtask

  initial begin
    logic [31:0] r32;
    rst = 1'b1; pv = 1'b0; prod = 64'd0; br = 1'b1;

    // Expected values below are for the LO-first instance.
    //  rst pv product                  br  pr bv bus_data      sel done hi            lo            ovf
    add(1, 0, 64'h0,                     1,  1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(0, 1, 64'hFFFFFFFF_FFFFFFF1,     1,  0, 1, 32'hFFFFFFF1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    add(0, 0, 64'h0,                     1,  0, 1, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    add(0, 0, 64'h0,                     1,  1, 0, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    add(0, 1, 64'h00000000_FFFFFFFE,     0,  0, 1, 32'hFFFFFFFE, 0, 0, 32'h0,        32'hFFFFFFFE, 1);
    for (int i = 0; i < 5; i++)
      add(0, 1, 64'h12345678_9ABCDEF0,   0,  0, 1, 32'hFFFFFFFE, 0, 0, 32'h0,        32'hFFFFFFFE, 1);
    add(0, 0, 64'h0,                     1,  0, 1, 32'h0,        1, 0, 32'h0,        32'hFFFFFFFE, 1);
    add(0, 0, 64'h0,                     1,  1, 0, 32'h0,        1, 1, 32'h0,        32'hFFFFFFFE, 1);
    add(0, 1, 64'h00000001_00000002,     1,  0, 1, 32'h2,        0, 0, 32'h1,        32'h2,        1);
    add(0, 0, 64'h0,                     1,  0, 1, 32'h1,        1, 0, 32'h1,        32'h2,        1);
    add(1, 0, 64'h0,                     1,  1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(0, 0, 64'h0,                     1,  1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
    add(0, 1, 64'h00000000_00000005,     1,  0, 1, 32'h5,        0, 0, 32'h0,        32'h5,        0);
    add(0, 1, 64'hFFFFFFFF_FFFFFFFD,     1,  0, 1, 32'h0,        1, 0, 32'h0,        32'h5,        0);
    add(0, 1, 64'hFFFFFFFF_FFFFFFFD,     1,  1, 0, 32'h0,        1, 1, 32'h0,        32'h5,        0);
    add(0, 1, 64'hFFFFFFFF_FFFFFFFD,     1,  0, 1, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    add(0, 0, 64'h0,                     1,  0, 1, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    add(0, 0, 64'h0,                     1,  1, 0, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; pv = tbl[i].pv; prod = tbl[i].prod; br = tbl[i].br;
      step();
      chk($sformatf("tbl%0d.prod_ready", i), 64'(pr0),   64'(tbl[i].pr));
      chk($sformatf("tbl%0d.bus_valid", i),  64'(bv0),   64'(tbl[i].bv));
      chk($sformatf("tbl%0d.bus_data", i),   64'(bd0),   64'(tbl[i].bd));
      chk($sformatf("tbl%0d.bus_sel", i),    64'(sel0),  64'(tbl[i].sel));
      chk($sformatf("tbl%0d.done", i),       64'(done0), 64'(tbl[i].done));
      chk($sformatf("tbl%0d.hi_out", i),     64'(hi0),   64'(tbl[i].hi));
      chk($sformatf("tbl%0d.lo_out", i),     64'(lo0),   64'(tbl[i].lo));
      chk($sformatf("tbl%0d.ovf", i),        64'(ovf0),  64'(tbl[i].ovf));
    end

    // HI-first instance: HI word leads, survives a stall, then LO follows.
    rst = 1'b1; pv = 1'b0; br = 1'b1; step();
    rst = 1'b0; pv = 1'b1; prod = 64'h00000001_00000002; br = 1'b0; step();
    chk("hf.first_data", 64'(bd1), 64'h1);
    chk("hf.first_sel",  64'(sel1), 64'h1);
    pv = 1'b0; step();
    chk("hf.stall_data", 64'(bd1), 64'h1);
    br = 1'b1; step();
    chk("hf.second_data", 64'(bd1), 64'h2);
    chk("hf.second_sel",  64'(sel1), 64'h0);
    step();
    chk("hf.done", 64'(done1), 64'h1);

    // Reset while the second word is pending: no done pulse may follow.
    pv = 1'b1; prod = 64'hDEADBEEF_00000001; step();
    pv = 1'b0; step();
    rst = 1'b1; step();
    chk("rs.bus_valid", 64'(bv0 | bv1), 64'h0);
    chk("rs.prod_ready", 64'({pr0, pr1}), 64'h3);
    rst = 1'b0; step();
    chk("rs.no_done", 64'(done0 | done1), 64'h0);

    for (int n = 0; n < 600; n++) begin
      r32  = $urandom;
      rst  = ($urandom_range(0, 49) == 0);
      pv   = ($urandom_range(0, 1) == 1);
      br   = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 2))
        0:       prod = {$urandom, $urandom};
        1:       prod = {{32{r32[31]}}, r32};
        default: prod = {{31{r32[0]}}, !r32[0], r32};
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
